periph_bus_master: RTL

- Initiator side of the peripheral address/data bus. It converts single load/store requests from the CPU memory stage into correctly timed bus cycles toward the peripheral manager.
- Handles byte/halfword access on a word-only bus: lane extraction and sign extension on reads, read-modify-write on sub-word stores.
- Checks alignment and the peripheral map, and returns one response per request.
- Sits between the memory stage and the peripheral manager; RAM-prefix (000) traffic never reaches it.

---
 rtl/periph_bus_master_pkg.sv | 20 ++
 rtl/periph_bus_master_if.sv | 30 +++
 rtl/periph_lane_unit.sv | 39 +++
 rtl/periph_bus_master.sv | 103 ++++++++++
 4 files changed

// File: rtl/periph_bus_master_pkg.sv
// periph_bus_master_pkg: shared size codes, prefix constants, FSM states and request check
package periph_bus_master_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [2:0] PFX_RAM  = 3'b000;
    localparam logic [2:0] PFX_PWM1 = 3'b001;
    localparam logic [2:0] PFX_BTN  = 3'b010;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

    // Reserved size, misaligned half/word, or a prefix with no peripheral behind it.
    function automatic logic req_bad(input logic [1:0] size, input logic [31:0] addr, input logic [7:0] mask);
        return (size == 2'b11) || (size == SZ_HALF && addr[0]) ||
               (size == SZ_WORD && addr[1:0] != 2'b00) || !mask[addr[31:29]];
    endfunction

endpackage

// File: rtl/periph_bus_master_if.sv
// periph_bus_master_if: request/response handshake plus word bus toward the peripheral manager
//   req_*  : load/store request from the memory stage (req_ready driven by the master)
//   resp_* : one-cycle response pulse
//   bus_*  : word address, write data/strobe out, read data in
interface periph_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] bus_addr;
    logic [31:0] bus_data_out;
    logic        bus_write_enable;
    logic [31:0] bus_data_in;

    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, bus_data_in,
        output req_ready, resp_valid, resp_rdata, resp_err, bus_addr, bus_data_out, bus_write_enable
    );

    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, bus_data_in,
        input  req_ready, resp_valid, resp_rdata, resp_err, bus_addr, bus_data_out, bus_write_enable
    );
endinterface

// File: rtl/periph_lane_unit.sv
// periph_lane_unit: byte/half lane extraction for loads and lane merge for sub-word stores
//   word       : word read from the bus
//   offset     : byte offset addr[1:0]
//   size       : SZ_BYTE / SZ_HALF / SZ_WORD
//   sign_ext   : sign-extend the extracted lane
//   wdata      : right-aligned store data
//   load_val   : extended load result
//   store_word : word with the target lanes replaced by wdata
module periph_lane_unit
    import periph_bus_master_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);
    logic [4:0]  bsh;
    logic [4:0]  hsh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] bmask;
    logic [31:0] hmask;

    always_comb begin
        bsh = {offset, 3'b000};
        hsh = {offset[1], 4'b0000};
        b = word[bsh +: 8];
        h = word[hsh +: 16];
        bmask = 32'h0000_00ff << bsh;
        hmask = 32'h0000_ffff << hsh;
        load_val = size == SZ_BYTE ? {{24{sign_ext & b[7]}}, b} :
                   size == SZ_HALF ? {{16{sign_ext & h[15]}}, h} : word;
        store_word = size == SZ_BYTE ? (word & ~bmask) | ({24'd0, wdata[7:0]} << bsh) :
                     size == SZ_HALF ? (word & ~hmask) | ({16'd0, wdata[15:0]} << hsh) : wdata;
    end
endmodule

// File: rtl/periph_bus_master.sv
// periph_bus_master: turns single load/store requests into timed word-bus cycles with sub-word RMW
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : periph_bus_master_if.master (request, response and peripheral bus signals)
module periph_bus_master
    import periph_bus_master_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [7:0]  MAPPED_MASK = ((8'd1 << PFX_PWM1) | (8'd1 << PFX_BTN)) & ~(8'd1 << PFX_RAM)
) (
    input logic clk,
    input logic rst_n,
    periph_bus_master_if.master bus
);
    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

    state_t      state, state_d;
    logic [2:0]  cnt, cnt_d;
    logic        wr_q, sgn_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic        acc, bad, rd_last;
    logic [29:0] f_waddr;
    logic [31:0] load_val, store_word;
    logic        ready_d, rv_d, err_d, we_d;
    logic [31:0] rdata_d, baddr_d, dout_d;

    // Lanes operate straight on bus_data_in so the sample happens at the edge ending the last RD cycle.
    periph_lane_unit u_lane (
        .word       (bus.bus_data_in),
        .offset     (addr_q[1:0]),
        .size       (size_q),
        .sign_ext   (sgn_q),
        .wdata      (wdata_q),
        .load_val   (load_val),
        .store_word (store_word)
    );

    always_comb begin
        acc = bus.req_valid && bus.req_ready;
        bad = req_bad(bus.req_size, bus.req_addr, MAPPED_MASK);
        rd_last = state == S_RD && cnt == WAIT_LAST;
        // In IDLE the request fields are not latched yet, so the first bus cycle uses them directly.
        f_waddr = state == S_IDLE ? bus.req_addr[31:2] : addr_q[31:2];
        state_d = state;
        cnt_d = cnt;
        case (state)
            S_IDLE: begin
                if (acc) state_d = bad ? S_RESP : (bus.req_write && bus.req_size == SZ_WORD) ? S_WR : S_RD;
                cnt_d = '0;
            end
            S_RD: begin
                state_d = !rd_last ? S_RD : wr_q ? S_WR : S_RESP;
                cnt_d = cnt + 3'd1;
            end
            S_WR: state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
        // Outputs are registered from the next state so each appears in the cycle of its state.
        ready_d = state_d == S_IDLE;
        rv_d = state_d == S_RESP;
        err_d = acc && bad;
        we_d = state_d == S_WR;
        baddr_d = (state_d == S_RD || state_d == S_WR) ? {f_waddr, 2'b00} : '0;
        dout_d = state_d != S_WR ? '0 : state == S_IDLE ? bus.req_wdata : store_word;
        rdata_d = (rd_last && !wr_q) ? load_val : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt <= '0;
            wr_q <= 1'b0;
            sgn_q <= 1'b0;
            size_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            bus.req_ready <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err <= 1'b0;
            bus.bus_addr <= '0;
            bus.bus_data_out <= '0;
            bus.bus_write_enable <= 1'b0;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
            if (acc) begin
                wr_q <= bus.req_write;
                sgn_q <= bus.req_signed;
                size_q <= bus.req_size;
                addr_q <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            bus.req_ready <= ready_d;
            bus.resp_valid <= rv_d;
            bus.resp_rdata <= rdata_d;
            bus.resp_err <= err_d;
            bus.bus_addr <= baddr_d;
            bus.bus_data_out <= dout_d;
            bus.bus_write_enable <= we_d;
        end
    end
endmodule
